// File: rtl/ones_mod4_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ones_mod4_pkg
//   Shared constants for the ones-count-mod-4 arbiter slice.
//   - FSM state encodings for the top-level controller (legacy 2-bit codes).
//   - MOD / COUNT_W describe the modulus of the serial ones counter.
//   - is_multiple() turns a residue into the "multiple of MOD" detection flag.
// ---------------------------------------------------------------------------
package ones_mod4_pkg;

  // Controller states. Kept as plain 2-bit constants so the encoding is
  // identical to older blocks that decode the state bus directly.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Modulus of the ones counter and the width needed to hold a residue.
  localparam int MOD     = 4;
  localparam int COUNT_W = $clog2(MOD);

  // A residue of zero means the ones count is a multiple of MOD
  // (an all-zero word counts as a multiple).
  function automatic logic is_multiple(input logic [COUNT_W-1:0] residue);
    return (residue == '0);
  endfunction

endpackage

// File: rtl/ones_mod4_arbiter_core.sv
// ---------------------------------------------------------------------------
// ones_mod4_core
//   Serial ones counter modulo 4. One input bit per enabled cycle; the
//   counter advances only when en and din are both high. clr wins over en so
//   a new job can be started in the same cycle the previous one is abandoned.
//
// Ports
//   clk    in   1  clock, all state on posedge
//   reset  in   1  synchronous active-high reset, clears the count
//   clr    in   1  clear count to 0 (priority over en)
//   en     in   1  consume din this cycle
//   din    in   1  serial data bit
//   count  out  2  ones seen since last clear/reset, modulo 4
// ---------------------------------------------------------------------------
module ones_mod4_core
  import ones_mod4_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic               din,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] count_next;

  // Natural wrap of the 2-bit register gives the mod-4 behaviour.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && din) begin
      count_next = count_reg + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ones_mod4_arbiter.sv
// ---------------------------------------------------------------------------
// ones_mod4_arbiter
//   Shares one serial ones-count-mod-4 checker between two requesters that
//   each present a parallel WIDTH-bit word. A round-robin arbiter picks one
//   requester in IDLE, the word is latched and shifted LSB-first into the
//   counter core, and the residue is offered on a valid/ready result port.
//
//   Timeline for a word accepted at cycle T:
//     T          : IDLE, reqN_ready high, word/id latched, core cleared
//     T+1..T+W   : SHIFT, one bit per cycle into the core
//     T+W+1      : DONE, res_valid high until res_ready
//
// Parameters
//   WIDTH         bits per request word (>= 1)
//
// Ports
//   clk           in   1      clock, all state on posedge
//   reset         in   1      synchronous active-high reset
//   req0_valid    in   1      requester 0 has a word
//   req0_data     in   WIDTH  requester 0 word, sampled on its accept cycle
//   req0_ready    out  1      requester 0 word accepted this cycle
//   req1_valid    in   1      requester 1 has a word
//   req1_data     in   WIDTH  requester 1 word, sampled on its accept cycle
//   req1_ready    out  1      requester 1 word accepted this cycle
//   res_valid     out  1      result available (DONE)
//   res_ready     in   1      consumer takes the result
//   res_detected  out  1      ones count is a multiple of 4 (incl. 0)
//   res_count     out  2      ones count mod 4
//   res_id        out  1      requester that owns the result
//   busy          out  1      high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module ones_mod4_arbiter
  import ones_mod4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_data,
  output logic               req1_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_detected,
  output logic [COUNT_W-1:0] res_count,
  output logic               res_id,
  output logic               busy
);

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  // Value of the bit counter during the final shift cycle.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]         state_reg,        state_next;
  logic               rr_ptr_reg,       rr_ptr_next;
  logic [WIDTH-1:0]   shreg_reg,        shreg_next;
  logic [CNT_W-1:0]   bitcnt_reg,       bitcnt_next;
  logic               id_reg,           id_next;

  // Last delivered result, shown on res_* while not in DONE.
  logic [COUNT_W-1:0] res_count_reg,    res_count_next;
  logic               res_detected_reg, res_detected_next;
  logic               res_id_reg,       res_id_next;

  // -------------------------------------------------------------------------
  // Request side: gather the two requesters into vectors so the grant and
  // ready logic is written once per requester.
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0]   req_data [NUM_REQ];

  assign req_valid   = {req1_valid, req0_valid};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  logic any_valid;
  logic grant_id;
  logic accept;

  assign any_valid = |req_valid;

  // Round robin: the pointed-to requester wins if it is asking, otherwise
  // the other one gets the slot. Only meaningful when any_valid is high.
  assign grant_id = req_valid[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;

  // Ready is gated by reset so no handshake is reported on a cycle whose
  // accept would be discarded by the reset.
  assign accept = (state_reg == ST_IDLE) && any_valid && !reset;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (grant_id == 1'(gi));
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // -------------------------------------------------------------------------
  // Counter core: cleared on accept, fed one bit per SHIFT cycle.
  // -------------------------------------------------------------------------
  logic               core_en;
  logic [COUNT_W-1:0] core_count;

  assign core_en = (state_reg == ST_SHIFT);

  ones_mod4_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (core_en),
    .din   (shreg_reg[0]),
    .count (core_count)
  );

  // -------------------------------------------------------------------------
  // Controller
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    shreg_next  = shreg_reg;
    bitcnt_next = bitcnt_reg;
    id_next     = id_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          shreg_next  = req_data[grant_id];
          bitcnt_next = '0;
          id_next     = grant_id;
          state_next  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shreg_next  = shreg_reg >> 1;
        bitcnt_next = bitcnt_reg + CNT_W'(1);
        if (bitcnt_reg == LAST_BIT) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          // The requester just served goes to the back of the line.
          rr_ptr_next = ~id_reg;
          state_next  = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Result holding registers track the live result while in DONE so that,
  // once the controller leaves DONE, res_* keep showing the last result even
  // though the core and id register move on with the next job.
  always_comb begin
    res_count_next    = res_count_reg;
    res_detected_next = res_detected_reg;
    res_id_next       = res_id_reg;
    if (state_reg == ST_DONE) begin
      res_count_next    = core_count;
      res_detected_next = is_multiple(core_count);
      res_id_next       = id_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      rr_ptr_reg       <= 1'b0;
      shreg_reg        <= '0;
      bitcnt_reg       <= '0;
      id_reg           <= 1'b0;
      res_count_reg    <= '0;
      res_detected_reg <= 1'b0;
      res_id_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      shreg_reg        <= shreg_next;
      bitcnt_reg       <= bitcnt_next;
      id_reg           <= id_next;
      res_count_reg    <= res_count_next;
      res_detected_reg <= res_detected_next;
      res_id_reg       <= res_id_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // In DONE the live core value is presented directly so the result is
  // visible in the very first DONE cycle; elsewhere the held copy is shown.
  assign res_valid    = (state_reg == ST_DONE);
  assign res_count    = res_valid ? core_count              : res_count_reg;
  assign res_detected = res_valid ? is_multiple(core_count) : res_detected_reg;
  assign res_id       = res_valid ? id_reg                  : res_id_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ones_mod4_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ones_mod4_arbiter
//   Directed and randomized jobs against a reference built from the plain
//   arithmetic definition: result = (number of 1 bits in the word) % 4,
//   detected = (result == 0), latency = WIDTH+1 cycles after accept,
//   round-robin pointer moves to the other requester after each result.
// ---------------------------------------------------------------------------
module tb_ones_mod4_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data,  req1_data;
  logic             req0_ready, req1_ready;
  logic             res_valid,  res_ready;
  logic             res_detected;
  logic [1:0]       res_count;
  logic             res_id;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ones_mod4_arbiter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_detected (res_detected),
    .res_count    (res_count),
    .res_id       (res_id),
    .busy         (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: popcount modulo 4.
  function automatic logic [1:0] ref_mod4(input logic [WIDTH-1:0] d);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(d[i]);
    return 2'(n % 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled 3 later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [WIDTH-1:0] d);
    if (id == 0) begin
      req0_valid = v;
      req0_data  = d;
    end else begin
      req1_valid = v;
      req1_data  = d;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"},    {req1_ready, req0_ready}, 0);
    check({tag, ".res_valid"}, res_valid, 0);
    check({tag, ".detected"}, res_detected, 0);
    check({tag, ".count"},    res_count, 0);
    check({tag, ".id"},       res_id, 0);
    check({tag, ".busy"},     busy, 0);
  endtask

  // One job from a single requester; the other requester raises valid while
  // the job is in flight to show it is ignored, and is dropped before the
  // handshake so it does not start a job of its own.
  task automatic do_job(input int id, input logic [WIDTH-1:0] data, input int hold,
                        input string name);
    logic [1:0] exp_cnt;
    logic       exp_id;
    int         lat;
    exp_cnt = ref_mod4(data);
    exp_id  = 1'(id);
    next_cyc();
    res_ready = 1'b0;
    set_req(id, 1'b1, data);
    #3;
    check({name, ".accept_ready"}, (id == 0) ? req0_ready : req1_ready, 1);
    check({name, ".other_ready"},  (id == 0) ? req1_ready : req0_ready, 0);
    next_cyc();
    set_req(id, 1'b0, WIDTH'($urandom));   // late data change must not matter
    set_req(1 - id, 1'b1, WIDTH'($urandom));
    lat = 0;
    for (int k = 1; k <= 3 * WIDTH; k++) begin
      #3;
      if (res_valid) begin
        lat = k;
        break;
      end
      check({name, ".shift_ready"}, {req1_ready, req0_ready}, 0);
      check({name, ".shift_busy"},  busy, 1);
      next_cyc();
    end
    check({name, ".latency"},  lat, WIDTH + 1);
    check({name, ".count"},    res_count, exp_cnt);
    check({name, ".detected"}, res_detected, (exp_cnt == 2'd0));
    check({name, ".id"},       res_id, exp_id);
    for (int h = 0; h < hold; h++) begin
      next_cyc();
      #3;
      check({name, ".hold_valid"}, res_valid, 1);
      check({name, ".hold_count"}, {res_id, res_detected, res_count},
            {exp_id, (exp_cnt == 2'd0), exp_cnt});
      check({name, ".hold_ready"}, {req1_ready, req0_ready}, 0);
    end
    next_cyc();
    set_req(1 - id, 1'b0, '0);
    res_ready = 1'b1;
    #3;
    check({name, ".hs_valid"}, res_valid, 1);
    next_cyc();
    res_ready = 1'b0;
    #3;
    check({name, ".post_valid"}, res_valid, 0);
    check({name, ".post_busy"},  busy, 0);
    check({name, ".post_held"},  {res_id, res_detected, res_count},
          {exp_id, (exp_cnt == 2'd0), exp_cnt});
    $display("job %-10s id=%0d data=%h count=%0d detected=%0d latency=%0d hold=%0d",
             name, id, data, res_count, res_detected, lat, hold);
  endtask

  initial begin
    logic       rr_model;
    logic       exp_grant;
    int         n_grants, n_results, last_grant_cyc;
    logic       grant_q[$];
    logic [WIDTH-1:0] d0, d1;
    int         lat;
    logic       gid;

    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    res_ready  = 1'b0;

    // ---- reset state ----
    next_cyc();
    next_cyc();
    #3;
    check_all_zero("reset_hold");
    next_cyc();
    reset = 1'b0;
    #3;
    check_all_zero("reset_release");

    // ---- zero word and directed counts ----
    do_job(0, 8'h00, 0, "zero");
    do_job(1, 8'h07, 0, "h07");
    do_job(0, 8'hFF, 0, "hFF");
    do_job(1, 8'h0F, 0, "h0F");
    do_job(0, 8'h01, 0, "h01");

    // ---- backpressure ----
    do_job(1, 8'h5B, 5, "backpress");

    // ---- randomized jobs ----
    for (int j = 0; j < 10; j++) begin
      do_job(int'($urandom_range(1)), WIDTH'($urandom), int'($urandom_range(3)),
             $sformatf("rand%0d", j));
    end

    // ---- contention from reset: grants alternate, fixed throughput ----
    next_cyc();
    reset      = 1'b1;
    d0         = 8'h03;
    d1         = 8'h1F;
    req0_valid = 1'b1;
    req0_data  = d0;
    req1_valid = 1'b1;
    req1_data  = d1;
    res_ready  = 1'b1;
    next_cyc();
    next_cyc();
    reset          = 1'b0;
    rr_model       = 1'b0;
    n_grants       = 0;
    n_results      = 0;
    last_grant_cyc = 0;
    for (int c = 0; c < 100 && n_results < 4; c++) begin
      #3;
      check("cont.exclusive", req0_ready & req1_ready, 0);
      if (req0_ready || req1_ready) begin
        exp_grant = rr_model;           // both always valid -> pointer wins
        check($sformatf("cont.grant%0d", n_grants), req1_ready, exp_grant);
        if (n_grants > 0) check("cont.interval", c - last_grant_cyc, WIDTH + 2);
        grant_q.push_back(req1_ready);
        last_grant_cyc = c;
        n_grants++;
      end
      if (res_valid && res_ready) begin
        gid = (grant_q.size() > 0) ? grant_q.pop_front() : 1'b0;
        check($sformatf("cont.res%0d_id", n_results), res_id, gid);
        check($sformatf("cont.res%0d_count", n_results), res_count,
              ref_mod4(gid ? d1 : d0));
        check($sformatf("cont.res%0d_det", n_results), res_detected,
              (ref_mod4(gid ? d1 : d0) == 2'd0));
        $display("contention result %0d id=%0d count=%0d detected=%0d",
                 n_results, res_id, res_count, res_detected);
        rr_model = ~gid;
        n_results++;
      end
      next_cyc();
    end
    check("cont.results", n_results, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    next_cyc();

    // ---- reset mid-SHIFT ----
    do_job(0, 8'h3C, 0, "pre_reset");   // leaves pointer at requester 1
    next_cyc();
    set_req(0, 1'b1, 8'hF0);
    #3;
    check("midrst.accept", req0_ready, 1);
    next_cyc();
    set_req(0, 1'b0, '0);               // shift cycle 1
    for (int s = 2; s <= 4; s++) next_cyc();
    reset = 1'b1;                       // during shift cycle 4
    next_cyc();
    #3;
    check_all_zero("midrst");
    next_cyc();
    reset = 1'b0;
    lat = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      #3;
      if (res_valid) lat++;
      next_cyc();
    end
    check("midrst.no_result", lat, 0);
    req0_valid = 1'b1;
    req0_data  = 8'h0E;
    req1_valid = 1'b1;
    req1_data  = 8'hFF;
    #3;
    check("midrst.first_grant", {req1_ready, req0_ready}, 2'b01);
    next_cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    lat = 0;
    for (int k = 1; k <= 3 * WIDTH; k++) begin
      #3;
      if (res_valid) begin
        lat = k;
        break;
      end
      next_cyc();
    end
    check("midrst.latency", lat, WIDTH + 1);
    check("midrst.id",      res_id, 0);
    check("midrst.count",   res_count, ref_mod4(8'h0E));
    $display("post-reset job id=%0d count=%0d latency=%0d", res_id, res_count, lat);
    next_cyc();
    res_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
